// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning block: FSM state
// encoding and default timing constants.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    localparam int CNT_W_DEFAULT           = 26;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int LONG_CYCLES_DEFAULT     = 50000000;
    localparam int REPEAT_CYCLES_DEFAULT   = 10000000;

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold timer for
// auto-repeat, and registered level/press/release/repeat outputs.
module button_channel
    import btn_pkg::*;
#(
    parameter int CNT_W           = CNT_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_C    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(LONG_CYCLES - REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit               DEB_ONE  = (DEBOUNCE_CYCLES == 1);

    logic             sync1;
    logic             sync2;
    btn_state_t       state;
    btn_state_t       state_d;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             repeat_d;
    logic             level_d;
    logic             press_d;
    logic             release_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RELEASED;
            deb_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_d;
            deb_cnt  <= deb_cnt_d;
            hold_cnt <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        deb_cnt_d  = deb_cnt;
        hold_cnt_d = hold_cnt;
        repeat_d   = 1'b0;
        case (state)
            RELEASED: begin
                if (sync2) begin
                    state_d   = PRESS_CHK;
                    deb_cnt_d = ONE;
                end
            end
            PRESS_CHK: begin
                if (!sync2) begin
                    state_d   = RELEASED;
                    deb_cnt_d = '0;
                end else if (DEB_ONE || (deb_cnt + ONE) == DEB_C) begin
                    state_d    = PRESSED;
                    deb_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt + ONE;
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_d   = RELEASE_CHK;
                    deb_cnt_d = ONE;
                end else if ((hold_cnt + ONE) == LONG_C) begin
                    // Reload so the following pulse lands REPEAT_CYCLES later.
                    repeat_d   = 1'b1;
                    hold_cnt_d = RELOAD_C;
                end else if (hold_cnt != CNT_MAX) begin
                    hold_cnt_d = hold_cnt + ONE;
                end
            end
            RELEASE_CHK: begin
                // hold_cnt is left untouched so a release glitch only pauses it.
                if (sync2) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                end else if (DEB_ONE || (deb_cnt + ONE) == DEB_C) begin
                    state_d   = RELEASED;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt + ONE;
                end
            end
            default: begin
                state_d   = RELEASED;
                deb_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        level_d   = (state_d == PRESSED) || (state_d == RELEASE_CHK);
        press_d   = (state == PRESS_CHK) && (state_d == PRESSED);
        release_d = (state == RELEASE_CHK) && (state_d == RELEASED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_repeat  <= 1'b0;
        end else begin
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            btn_repeat  <= repeat_d;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Conditions NUM_BTN raw push-buttons into clean levels plus press, release
// and auto-repeat pulses; each bit is an independent button_channel.
module button_debounce
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int CNT_W           = CNT_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_channel #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with short timing parameters; expected
// pulse events are queued with their edge number and matched by a monitor.
module tb_button_debounce;

    localparam int NB = 5;
    localparam int EW = 32 + 3 * NB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [EW-1:0] exp_q[$];

    button_debounce #(
        .NUM_BTN         (NB),
        .CNT_W           (26),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    // clock / edge counter: after posedge n, cyc == n
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [NB-1:0] p,
                        input logic [NB-1:0] r, input logic [NB-1:0] t);
        exp_q.push_back({32'(c), p, r, t});
    endtask

    task automatic step_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_level(input string name, input logic [NB-1:0] exp);
        checks++;
        if (btn_level !== exp) begin
            failures++;
            $display("FAIL %s: btn_level=%b expected=%b at cyc=%0d", name, btn_level, exp, cyc);
        end
    endtask

    // scoreboard monitor: every cycle with any pulse must match the next expectation
    always @(negedge clk) begin
        logic [EW-1:0] obs;
        logic [EW-1:0] e;
        if ((|btn_press) || (|btn_release) || (|btn_repeat)) begin
            obs = {32'(cyc), btn_press, btn_release, btn_repeat};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: cyc=%0d press=%b release=%b repeat=%b expected none",
                         cyc, btn_press, btn_release, btn_repeat);
            end else begin
                e = exp_q.pop_front();
                if (e !== obs) begin
                    failures++;
                    $display("FAIL event: got cyc=%0d p=%b r=%b t=%b expected cyc=%0d p=%b r=%b t=%b",
                             cyc, btn_press, btn_release, btn_repeat,
                             e[EW-1:3*NB], e[3*NB-1:2*NB], e[2*NB-1:NB], e[NB-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: cyc=%0d expected run to complete", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int d;

        // reset state
        repeat (3) @(negedge clk);
        check_level("reset_level", '0);
        checks++;
        if ((btn_press | btn_release | btn_repeat) !== '0) begin
            failures++;
            $display("FAIL reset_pulses: p=%b r=%b t=%b expected 0", btn_press, btn_release, btn_repeat);
        end
        rst = 1'b0;
        @(negedge clk);

        // 1: clean press and release on ch0
        c = cyc;
        btn_raw[0] = 1'b1;
        push(c + 6, 5'b00001, 5'b00000, 5'b00000);
        step_to(c + 5);  check_level("t1_before_press", 5'b00000);
        step_to(c + 6);  check_level("t1_press_level", 5'b00001);
        step_to(c + 10); btn_raw[0] = 1'b0;
        push(c + 16, 5'b00000, 5'b00001, 5'b00000);
        step_to(c + 15); check_level("t1_before_release", 5'b00001);
        step_to(c + 16); check_level("t1_released", 5'b00000);
        step_to(c + 20);

        // 2: 3-cycle burst, 1-cycle gap, then steady high on ch1
        c = cyc;
        btn_raw[1] = 1'b1;
        step_to(c + 3);  btn_raw[1] = 1'b0;
        step_to(c + 4);  btn_raw[1] = 1'b1;
        push(c + 10, 5'b00010, 5'b00000, 5'b00000);
        step_to(c + 6);  check_level("t2_burst_rejected", 5'b00000);
        step_to(c + 9);  check_level("t2_before_press", 5'b00000);
        step_to(c + 10); check_level("t2_press_level", 5'b00010);
        step_to(c + 14); btn_raw[1] = 1'b0;
        push(c + 20, 5'b00000, 5'b00010, 5'b00000);
        step_to(c + 24);

        // 3: hold ch2 for 60 cycles -> five repeats, then release
        c = cyc;
        btn_raw[2] = 1'b1;
        push(c + 6, 5'b00100, 5'b00000, 5'b00000);
        for (int k = 0; k < 5; k++)
            push(c + 26 + 8 * k, 5'b00000, 5'b00000, 5'b00100);
        push(c + 66, 5'b00000, 5'b00100, 5'b00000);
        step_to(c + 60); btn_raw[2] = 1'b0;
        step_to(c + 65); check_level("t3_before_release", 5'b00100);
        step_to(c + 66); check_level("t3_released", 5'b00000);
        step_to(c + 70);

        // 4: 2-cycle release glitch on ch3 pauses the hold timer for 3 edges
        c = cyc;
        btn_raw[3] = 1'b1;
        push(c + 6, 5'b01000, 5'b00000, 5'b00000);
        step_to(c + 10); btn_raw[3] = 1'b0;
        step_to(c + 12); btn_raw[3] = 1'b1;
        step_to(c + 14); check_level("t4_glitch_level", 5'b01000);
        push(c + 29, 5'b00000, 5'b00000, 5'b01000);
        push(c + 37, 5'b00000, 5'b00000, 5'b01000);
        push(c + 46, 5'b00000, 5'b01000, 5'b00000);
        step_to(c + 40); btn_raw[3] = 1'b0;
        step_to(c + 50);

        // 5: reset with ch0 in PRESSED and ch4 in PRESS_CHK
        c = cyc;
        btn_raw[0] = 1'b1;
        push(c + 6, 5'b00001, 5'b00000, 5'b00000);
        step_to(c + 10); btn_raw[4] = 1'b1;
        step_to(c + 13);
        rst = 1'b1;
        #1;
        check_level("t5_reset_level", 5'b00000);
        checks++;
        if ((btn_press | btn_release | btn_repeat) !== '0) begin
            failures++;
            $display("FAIL t5_reset_pulses: p=%b r=%b t=%b expected 0", btn_press, btn_release, btn_repeat);
        end
        btn_raw[4] = 1'b0;
        step_to(c + 16);
        rst = 1'b0;
        d = cyc;
        push(d + 6, 5'b00001, 5'b00000, 5'b00000);
        step_to(d + 5);  check_level("t5_redebounce", 5'b00000);
        step_to(d + 6);  check_level("t5_repress_level", 5'b00001);
        step_to(d + 10); btn_raw[0] = 1'b0;
        push(d + 16, 5'b00000, 5'b00001, 5'b00000);
        step_to(d + 20);

        // 6: all channels rise and fall together
        c = cyc;
        btn_raw = 5'b11111;
        push(c + 6, 5'b11111, 5'b00000, 5'b00000);
        step_to(c + 6);  check_level("t6_all_level", 5'b11111);
        step_to(c + 10); btn_raw = 5'b00000;
        push(c + 16, 5'b00000, 5'b11111, 5'b00000);
        step_to(c + 20); check_level("t6_all_released", 5'b00000);
        step_to(c + 30);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events: %0d expected events never seen, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
